uart_tx_master: RTL and testbench
=================================

Name: uart_tx_master

Overview:
UART transmitter, the transmit counterpart to the design's 8N1 receive path; serializes one byte per request onto the tx line, LSB first.
Bit timing comes from an internal divider that restarts at each frame start, so every bit is exactly DIV clocks with no phase jitter.
Sits between the host-side command/response logic and the board TX pin.

Parameters:
CLK_FREQUENCY, 100000000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; DIV = (CLK_FREQUENCY + BAUD_RATE/2) / BAUD_RATE clocks per bit, must be >= 2
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
tx_data  input  8  byte to send; sampled only on an accepted request
tx_start  input  1  request; accepted when tx_start & tx_ready in the same cycle
tx_ready  output  1  high when idle and able to accept a request
tx_done  output  1  one-cycle pulse in the last cycle of the final stop bit
tx  output  1  serial line, idle high, registered

Behaviour:
- Reset (reset low, async): tx=1, tx_ready=1, tx_done=0, FSM=IDLE, divider=0, bit index=0, shift register=0. A frame in flight is abandoned: tx returns high immediately with no partial stop bit.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when enabled).
- IDLE: tx=1, tx_ready=1. On accept in cycle N: latch tx_data into the shift register, clear the divider, go to START. At N+1: tx=0, tx_ready=0.
- Divider counts 0..DIV-1. Each state holds tx for exactly DIV cycles; the transition happens when divider==DIV-1.
- START -> DATA. DATA sends bit 0 first, shifting right once per bit; after 8 bits go to STOP (or PARITY).
- STOP: tx=1 for STOP_BITS*DIV cycles. tx_done=1 in the last of those cycles. The next cycle is IDLE with tx_ready=1.
- Full frame length: (10 + STOP_BITS - 1) * DIV cycles, counted from the first tx=0 cycle through the tx_done cycle.
- tx_start while tx_ready=0 is ignored (no queueing). tx_data changes mid-frame have no effect.
- A request in the cycle right after tx_done is accepted, which gives back-to-back frames with no idle gap beyond the stop bit(s).
- tx_ready is combinational from the FSM state (IDLE), not from tx_start.
- Divider width: $clog2(DIV*STOP_BITS) bits minimum. No wrap-around is possible because the count resets every state.

Optional Feature:
UART_TX_PARITY_EN defined:
- PARITY state inserted between DATA and STOP, lasting DIV cycles.
- tx = ^latched byte (even parity).
- Frame length grows by DIV.
UART_TX_PARITY_EN undefined:
- No PARITY state; plain 8N1 / 8N2 framing.

Decomposition:
- Shared package uart_pkg: FSM state typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP}, UART_DATA_BITS=8, and a function computing DIV from frequency/baud. The receive side reuses these.
- One natural sub-module: uart_tx_bit_timer (divider with clear and terminal-count output, parameter DIV). The FSM and shift register stay in uart_tx_master.

Test Plan:
- Reset/idle: CLK_FREQUENCY=1000, BAUD_RATE=100 (DIV=10); hold reset low, release -> tx=1, tx_ready=1, tx_done=0, and all stay constant for 100 cycles.
- Single byte 0xA5 accepted at cycle N -> tx low over cycles N+1..N+10; then bits 1,0,1,0,0,1,0,1 for 10 cycles each; stop high; tx_done pulses at cycle N+100; tx_ready=1 at N+101.
- Back-to-back 0x00 then 0xFF, second tx_start asserted in the cycle after tx_done -> second start bit at N+102, no extra idle; line decodes to 0x00, 0xFF.
- tx_start and tx_data=0x3C pulsed mid-frame of 0x55 -> ignored; only 0x55 transmitted; tx_ready stays low until frame end.
- Reset asserted at bit 4 of 0x81 -> tx=1 asynchronously, before the next clk edge; after release a new 0x81 request transmits a full, correct frame.
- STOP_BITS=2 and UART_TX_PARITY_EN defined, byte 0x07 -> parity bit=1, stop high for 20 cycles, tx_done at cycle N+120.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

    localparam int UART_DATA_BITS = 8;

    // Rounded clocks-per-bit for a given clock frequency and line rate.
    function automatic int uart_div(input int clk_frequency, input int baud_rate);
        return (clk_frequency + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period divider: counts from 0 while clear is low and flags the end of
// one bit period and the end of the stop span.
module uart_tx_bit_timer #(
    parameter int DIV  = 868,
    parameter int SPAN = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end,
    output logic span_end
);
    localparam int W = $clog2(DIV * SPAN);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

    assign bit_end  = (cnt == W'(DIV - 1));
    assign span_end = (cnt == W'(DIV * SPAN - 1));

endmodule

// File: rtl/uart_tx_master.sv
// UART transmitter, 8 data bits LSB first, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit(s).
module uart_tx_master
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100000000,
    parameter int BAUD_RATE     = 115200,
    parameter int STOP_BITS     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx
);
    localparam int DIV = uart_div(CLK_FREQUENCY, BAUD_RATE);

    uart_state_t state, state_nx;
    logic [7:0]  shreg, shreg_nx;
    logic [2:0]  bit_idx, bit_idx_nx;
    logic        tx_nx;
    logic        tmr_clr, bit_end, span_end;
`ifdef UART_TX_PARITY_EN
    logic        par, par_nx;
`endif

    uart_tx_bit_timer #(.DIV(DIV), .SPAN(STOP_BITS)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clr),
        .bit_end  (bit_end),
        .span_end (span_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            bit_idx <= bit_idx_nx;
            tx      <= tx_nx;
`ifdef UART_TX_PARITY_EN
            par     <= par_nx;
`endif
        end
    end

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_idx_nx = bit_idx;
        tmr_clr    = 1'b0;
        tx_done    = 1'b0;
        tx_ready   = (state == IDLE);
`ifdef UART_TX_PARITY_EN
        par_nx     = par;
`endif
        case (state)
            IDLE: begin
                tmr_clr = 1'b1;
                if (tx_start) begin
                    shreg_nx   = tx_data;
                    bit_idx_nx = '0;
                    state_nx   = START;
`ifdef UART_TX_PARITY_EN
                    par_nx     = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    tmr_clr  = 1'b1;
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    tmr_clr    = 1'b1;
                    shreg_nx   = {1'b0, shreg[7:1]};
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'(UART_DATA_BITS - 1))
`ifdef UART_TX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tmr_clr  = 1'b1;
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                // Stop span covers all stop bits in one count.
                if (span_end) begin
                    tmr_clr  = 1'b1;
                    tx_done  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Line level follows the state being entered, so tx is registered.
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shreg_nx[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_nx = par_nx;
`endif
            default: tx_nx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_master.sv
// Bench for uart_tx_master: frame-level model of the line plus directed checks.
// Two instances share clock and reset: STOP_BITS=1 and STOP_BITS=2.
module tb_uart_tx_master;
    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       st [2];
    logic [7:0] dat [2];
    logic       rdy [2];
    logic       done [2];
    logic       txl [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_master #(.CLK_FREQUENCY(1000), .BAUD_RATE(100), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .tx_data(dat[0]), .tx_start(st[0]),
        .tx_ready(rdy[0]), .tx_done(done[0]), .tx(txl[0]));

    uart_tx_master #(.CLK_FREQUENCY(1000), .BAUD_RATE(100), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .tx_data(dat[1]), .tx_start(st[1]),
        .tx_ready(rdy[1]), .tx_done(done[1]), .tx(txl[1]));

    // Model: a frame is a list of line levels, each held DIV cycles.
    int          sb [2] = '{1, 2};
    logic        busy [2] = '{1'b0, 1'b0};
    int          k [2] = '{0, 0};
    int          nb [2] = '{0, 0};
    logic [11:0] bits [2];

    function automatic logic [11:0] frame_bits(input logic [7:0] d);
        logic [11:0] fb;
        fb = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = d[i];
        if (PAR != 0) fb[9] = ^d;
        return fb;
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                busy[d] = 1'b0;
                k[d] = 0;
            end else if (busy[d]) begin
                if (k[d] == nb[d] * DIV) busy[d] = 1'b0;
                else k[d] = k[d] + 1;
            end else if (st[d]) begin
                busy[d] = 1'b1;
                k[d] = 1;
                bits[d] = frame_bits(dat[d]);
                nb[d] = 9 + PAR + sb[d];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                logic et, ed, er;
                et = busy[d] ? bits[d][(k[d] - 1) / DIV] : 1'b1;
                ed = busy[d] && (k[d] == nb[d] * DIV);
                er = !busy[d];
                chk(d == 0 ? "model_tx0" : "model_tx1", 32'(txl[d]), 32'(et));
                chk(d == 0 ? "model_done0" : "model_done1", 32'(done[d]), 32'(ed));
                chk(d == 0 ? "model_ready0" : "model_ready1", 32'(rdy[d]), 32'(er));
            end
        end
    end

    task automatic at_cycle(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic send(input int d, input logic [7:0] v, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy[d] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout dut%0d: ready never rose, expected 1", d);
        end
        st[d] = 1'b1;
        dat[d] = v;
        acc = cyc;
        @(negedge clk);
        st[d] = 1'b0;
    endtask

    task automatic decode(input int d, input int acc, output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            at_cycle(acc + 1 + DIV * (1 + i) + DIV / 2);
            b[i] = txl[d];
        end
    endtask

    initial begin
        int n, m;
        logic [7:0] b;
        st[0] = 1'b0; st[1] = 1'b0;
        dat[0] = 8'h00; dat[1] = 8'h00;
        #1 chk_en = 1'b1;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;

        // Idle after reset
        repeat (100) @(negedge clk);
        chk("idle_tx", 32'(txl[0]), 32'd1);
        chk("idle_ready", 32'(rdy[0]), 32'd1);
        chk("idle_done", 32'(done[0]), 32'd0);

        // Single byte 0xA5
        send(0, 8'hA5, n);
        at_cycle(n + 1);   chk("a5_start_first", 32'(txl[0]), 32'd0);
        at_cycle(n + 10);  chk("a5_start_last", 32'(txl[0]), 32'd0);
        at_cycle(n + 11);  chk("a5_bit0", 32'(txl[0]), 32'd1);
        at_cycle(n + 21);  chk("a5_bit1", 32'(txl[0]), 32'd0);
        at_cycle(n + 81);  chk("a5_bit7", 32'(txl[0]), 32'd1);
        at_cycle(n + 91);  chk("a5_stop", 32'(txl[0]), 32'd1);
        at_cycle(n + 99);  chk("a5_done_early", 32'(done[0]), 32'd0);
        at_cycle(n + 100); chk("a5_done", 32'(done[0]), 32'd1);
        at_cycle(n + 101); chk("a5_ready", 32'(rdy[0]), 32'd1);
        at_cycle(n + 105);

        // Back-to-back 0x00 then 0xFF
        send(0, 8'h00, n);
        decode(0, n, b);
        chk("b2b_byte0", 32'(b), 32'h00);
        at_cycle(n + 100); chk("b2b_done0", 32'(done[0]), 32'd1);
        at_cycle(n + 101);
        st[0] = 1'b1; dat[0] = 8'hFF;
        @(negedge clk);
        st[0] = 1'b0;
        chk("b2b_start2", 32'(txl[0]), 32'd0);
        decode(0, n + 101, b);
        chk("b2b_byte1", 32'(b), 32'hFF);
        at_cycle(n + 101 + 105);

        // Request mid-frame is ignored
        send(0, 8'h55, n);
        fork
            decode(0, n, b);
            begin
                at_cycle(n + 40);
                st[0] = 1'b1; dat[0] = 8'h3C;
                chk("ign_ready_low", 32'(rdy[0]), 32'd0);
                @(negedge clk);
                st[0] = 1'b0;
            end
        join
        chk("ign_byte", 32'(b), 32'h55);
        at_cycle(n + 100); chk("ign_ready_end", 32'(rdy[0]), 32'd0);
        at_cycle(n + 101); chk("ign_ready_after", 32'(rdy[0]), 32'd1);
        at_cycle(n + 105);

        // Reset mid-frame at bit 4 of 0x81
        send(0, 8'h81, n);
        at_cycle(n + 55);
        chk("rst_bit4_low", 32'(txl[0]), 32'd0);
        #2 reset = 1'b0;
        #1 chk("rst_async_tx", 32'(txl[0]), 32'd1);
        chk("rst_async_ready", 32'(rdy[0]), 32'd1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        send(0, 8'h81, n);
        decode(0, n, b);
        chk("rst_refr_byte", 32'(b), 32'h81);
        at_cycle(n + 100); chk("rst_refr_done", 32'(done[0]), 32'd1);
        at_cycle(n + 105);

        // Two stop bits (plus parity when enabled), byte 0x07
        send(1, 8'h07, m);
        decode(1, m, b);
        chk("sb2_byte", 32'(b), 32'h07);
`ifdef UART_TX_PARITY_EN
        at_cycle(m + 95);  chk("sb2_parity", 32'(txl[1]), 32'd1);
        at_cycle(m + 101); chk("sb2_stop_first", 32'(txl[1]), 32'd1);
        at_cycle(m + 119); chk("sb2_done_early", 32'(done[1]), 32'd0);
        at_cycle(m + 120); chk("sb2_done", 32'(done[1]), 32'd1);
        at_cycle(m + 121); chk("sb2_ready", 32'(rdy[1]), 32'd1);
`else
        at_cycle(m + 91);  chk("sb2_stop_first", 32'(txl[1]), 32'd1);
        at_cycle(m + 109); chk("sb2_done_early", 32'(done[1]), 32'd0);
        at_cycle(m + 110); chk("sb2_done", 32'(done[1]), 32'd1);
        at_cycle(m + 111); chk("sb2_ready", 32'(rdy[1]), 32'd1);
`endif
        at_cycle(m + 130);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
